// File: rtl/mul_share_sched_pkg.sv
// Shared types and defaults for the multiplier-sharing scheduler.
// Build option: MUL_TIMEOUT_EN (see mul_share_sched).
package mul_sched_pkg;

    localparam int unsigned DEF_DWIDTH = 8;
    localparam int unsigned DEF_NREQ   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Requester ID width; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_share_sched_if.sv
// Requester / response bus between client blocks and the scheduler.
interface mul_share_sched_if
    import mul_sched_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned OWIDTH = 2 * DWIDTH
);
    localparam int unsigned IDW = id_width(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DWIDTH-1:0] req_x;
    logic [NREQ*DWIDTH-1:0] req_y;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [OWIDTH-1:0]      rsp_z;
    logic                   rsp_err;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_err
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z, rsp_err
    );

endinterface

// File: rtl/mul_share_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import mul_sched_pkg::*;
#(
    parameter int unsigned N   = DEF_NREQ,
    parameter int unsigned IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!any && req[IDW'(idx)]) begin
                any                     = 1'b1;
                gnt_idx                 = IDW'(idx);
                gnt_onehot[IDW'(idx)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one start/done multiplier among NREQ requesters.
// Optional build macro MUL_TIMEOUT_EN adds a WAIT watchdog that aborts with rsp_err=1.
module mul_share_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned DWIDTH  = DEF_DWIDTH,
    parameter int unsigned OWIDTH  = 2 * DWIDTH,
    parameter int unsigned NREQ    = DEF_NREQ
`ifdef MUL_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 4 * DWIDTH
`endif
) (
    input  logic              clk,
    input  logic              rst,
    mul_share_sched_if.slave  bus,
    output logic [DWIDTH-1:0] mul_x,
    output logic [DWIDTH-1:0] mul_y,
    output logic              mul_start,
    input  logic [OWIDTH-1:0] mul_z,
    input  logic              mul_done
);

    localparam int unsigned IDW = id_width(NREQ);

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [NREQ-1:0]   gnt_onehot;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_any;
    logic              accept;
    logic              expired;
    logic [DWIDTH-1:0] sel_x;
    logic [DWIDTH-1:0] sel_y;

    rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
        .req        (bus.req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign accept = (state == S_IDLE) && gnt_any;

    // One-hot operand mux for the granted requester.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_onehot[i]) begin
                sel_x = sel_x | bus.req_x[i*DWIDTH +: DWIDTH];
                sel_y = sel_y | bus.req_y[i*DWIDTH +: DWIDTH];
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;

    // Watchdog: cleared while issuing, counts each WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT && !expired) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign expired = (state == S_WAIT) && (wd_cnt == TW'(TIMEOUT - 1));

    // Error flag: a real mul_done always beats a simultaneous expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_err <= 1'b0;
        end else if (state == S_WAIT) begin
            if (mul_done) begin
                bus.rsp_err <= 1'b0;
            end else if (expired) begin
                bus.rsp_err <= 1'b1;
            end
        end
    end
`else
    assign expired     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (gnt_any) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mul_done || expired) state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; the grant is only visible while idle.
    always_comb begin
        bus.req_ready = '0;
        mul_start     = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            S_IDLE:  bus.req_ready = gnt_onehot;
            S_ISSUE: mul_start     = 1'b1;
            S_RESP:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture operands, owner and pointer on grant; hold them until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            mul_x      <= '0;
            mul_y      <= '0;
            bus.rsp_id <= '0;
        end else if (accept) begin
            mul_x      <= sel_x;
            mul_y      <= sel_y;
            bus.rsp_id <= gnt_idx;
            rr_ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Product capture; a watchdog abort returns zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_z <= '0;
        end else if (state == S_WAIT) begin
            if (mul_done) begin
                bus.rsp_z <= mul_z;
            end else if (expired) begin
                bus.rsp_z <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched with a start/done shift-add multiplier model.
module tb_mul_share_sched;
    import mul_sched_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned OW = 2 * DW;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [OW-1:0] z;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] mul_x;
    logic [DW-1:0] mul_y;
    logic          mul_start;
    logic [OW-1:0] mul_z;
    logic          mul_done;
    logic [DW-1:0] xs [NR];
    logic [DW-1:0] ys [NR];
    logic          kill;
    logic          stray;
    exp_t          exp_q [$];
    int            errors = 0;
    int            checks = 0;

    mul_share_sched_if #(.DWIDTH(DW), .NREQ(NR)) bus ();

    mul_share_sched #(.DWIDTH(DW), .NREQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_start (mul_start),
        .mul_z     (mul_z),
        .mul_done  (mul_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bus.req_x[i*DW +: DW] = xs[i];
            bus.req_y[i*DW +: DW] = ys[i];
        end
    end

    // Reference multiplier: done pulses DW+3 cycles after start.
    logic          m_busy;
    logic          m_done;
    int            m_cnt;
    logic [OW-1:0] m_z;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_z    <= '0;
        end else begin
            m_done <= 1'b0;
            if (mul_start && !m_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_z    <= OW'(mul_x) * OW'(mul_y);
            end else if (m_busy) begin
                if (m_cnt == DW + 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end
    assign mul_z    = m_z;
    assign mul_done = (m_done & ~kill) | stray;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one request and hold it until granted; returns in the ISSUE cycle.
    task automatic request(input logic [IW-1:0] id, input logic [DW-1:0] x, input logic [DW-1:0] y);
        int n;
        n = 0;
        xs[id] = x;
        ys[id] = y;
        bus.req_valid[id] = 1'b1;
        #1;
        while (!bus.req_ready[id] && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.req_ready[id]) begin
            errors++;
            $display("FAIL req_grant: requester %0d ready=0 after %0d cycles, required 1", id, n);
            bus.req_valid[id] = 1'b0;
        end else begin
            exp_q.push_back('{id: id, z: OW'(x) * OW'(y), err: 1'b0});
            tick();
            bus.req_valid[id] = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int limit, output int n, output int starts);
        n = 0;
        starts = 0;
        while (!bus.rsp_valid && n < limit) begin
            if (mul_start) starts++;
            tick();
            n++;
        end
        checks++;
        if (!bus.rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_err, mul_x, mul_y, mul_start} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b z=%0d mul_x=%0d start=%b, required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_z, mul_x, mul_start);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n, starts;
        exp_t e;
        xs[0] = 8'd2;
        ys[0] = 8'd3;
        bus.req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b, required 0001", bus.req_ready);
        end
        exp_q.push_back('{id: 2'd0, z: 16'd6, err: 1'b0});
        tick();
        bus.req_valid = '0;
        wait_rsp(60, n, starts);
        checks++;
        if (n != DW + 4) begin
            errors++;
            $display("FAIL single_latency: rsp_valid %0d cycles after ISSUE, required %0d", n, DW + 4);
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL single_start_pulses: got %0d, required 1", starts);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_z, bus.rsp_err} !== {e.id, e.z, e.err}) begin
            errors++;
            $display("FAIL single_rsp: got id=%0d z=%0d err=%b, required id=%0d z=%0d err=%b",
                     bus.rsp_id, bus.rsp_z, bus.rsp_err, e.id, e.z, e.err);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp_drop: rsp_valid=%b after handshake, required 0", bus.rsp_valid);
        end
    endtask

    task automatic test_rotation();
        int grants, got, n;
        exp_t e;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            xs[i] = DW'(i + 1);
            ys[i] = 8'd10;
        end
        bus.req_valid = 4'b1111;
        #1;
        grants = 0;
        got = 0;
        n = 0;
        while (got < 2 * NR && n < 400) begin
            if (bus.req_ready != '0 && grants < 2 * NR) begin
                checks++;
                if (bus.req_ready !== (NR'(1) << (grants % NR))) begin
                    errors++;
                    $display("FAIL rotation_grant: grant %0d ready=%b, required one-hot bit %0d",
                             grants, bus.req_ready, grants % NR);
                end
                exp_q.push_back('{id: IW'(grants % NR), z: OW'((grants % NR + 1) * 10), err: 1'b0});
                grants++;
            end
            if (bus.rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rotation_rsp: unexpected response id=%0d z=%0d, required none",
                             bus.rsp_id, bus.rsp_z);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_z, bus.rsp_err} !== {e.id, e.z, e.err}) begin
                        errors++;
                        $display("FAIL rotation_rsp: got id=%0d z=%0d err=%b, required id=%0d z=%0d err=%b",
                                 bus.rsp_id, bus.rsp_z, bus.rsp_err, e.id, e.z, e.err);
                    end
                end
                got++;
            end
            tick();
            n++;
            if (grants == 2 * NR) bus.req_valid = '0;
        end
        checks++;
        if (got != 2 * NR) begin
            errors++;
            $display("FAIL rotation_count: got %0d responses, required %0d", got, 2 * NR);
        end
    endtask

    task automatic test_max();
        int n;
        bit stable;
        exp_t e;
        request(2'd2, 8'd255, 8'd255);
        xs[2] = 8'h00;
        ys[2] = 8'h00;
        stable = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 60) begin
            if (mul_x !== 8'hFF || mul_y !== 8'hFF) stable = 1'b0;
            tick();
            n++;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL max_operand_hold: mul_x/mul_y changed before done, required 255/255");
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_z} !== {1'b1, 2'd2, 16'hFE01} || e.z !== 16'hFE01) begin
            errors++;
            $display("FAIL max_rsp: got valid=%b id=%0d z=%h, required valid=1 id=2 z=fe01",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_z);
        end
        tick();
    endtask

    task automatic test_wrap();
        int n, starts;
        exp_t e;
        xs[1] = 8'd13;
        ys[1] = 8'd17;
        bus.req_valid = 4'b0010;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ready: got %b, required 0010", bus.req_ready);
        end
        exp_q.push_back('{id: 2'd1, z: 16'd221, err: 1'b0});
        tick();
        bus.req_valid = '0;
        wait_rsp(60, n, starts);
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_z, bus.rsp_err} !== {e.id, e.z, e.err}) begin
            errors++;
            $display("FAIL wrap_rsp: got id=%0d z=%0d err=%b, required id=%0d z=%0d err=%b",
                     bus.rsp_id, bus.rsp_z, bus.rsp_err, e.id, e.z, e.err);
        end
        tick();
    endtask

    task automatic test_stall();
        int n, starts;
        bit held, quiet;
        logic [OW+IW+1:0] snap;
        exp_t e;
        bus.rsp_ready = 1'b0;
        request(2'd0, 8'd7, 8'd9);
        wait_rsp(60, n, starts);
        snap = {bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_err};
        bus.req_valid = 4'b1111;
        held = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            tick();
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_err} !== snap) held = 1'b0;
            if (bus.req_ready !== 4'b0000) quiet = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL stall_hold: rsp changed to valid=%b z=%0d, required held valid=1 z=63",
                     bus.rsp_valid, bus.rsp_z);
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL stall_ready: req_ready went nonzero during stall, required 0000");
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_z, bus.rsp_err} !== {e.id, e.z, e.err}) begin
            errors++;
            $display("FAIL stall_rsp: got id=%0d z=%0d err=%b, required id=%0d z=%0d err=%b",
                     bus.rsp_id, bus.rsp_z, bus.rsp_err, e.id, e.z, e.err);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_stray_done();
        bit quiet;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        quiet = 1'b1;
        repeat (5) begin
            if (bus.rsp_valid !== 1'b0 || mul_start !== 1'b0) quiet = 1'b0;
            tick();
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL stray_done: rsp_valid/mul_start asserted after idle mul_done, required 0");
        end
    endtask

    task automatic test_reset_mid();
        int n, starts;
        exp_t e;
        request(2'd1, 8'd5, 8'd6);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_z, bus.rsp_err, mul_x, mul_y, mul_start} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: rsp_z=%0d rsp_id=%0d mul_x=%0d mul_y=%0d, required all 0",
                     bus.rsp_z, bus.rsp_id, mul_x, mul_y);
        end
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        request(2'd3, 8'd12, 8'd11);
        wait_rsp(60, n, starts);
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_z, bus.rsp_err} !== {2'd3, 16'd132, 1'b0} || e.z !== 16'd132) begin
            errors++;
            $display("FAIL reset_mid_fresh: got id=%0d z=%0d err=%b, required id=3 z=132 err=0",
                     bus.rsp_id, bus.rsp_z, bus.rsp_err);
        end
        tick();
    endtask

`ifdef MUL_TIMEOUT_EN
    task automatic test_timeout();
        int n, starts;
        exp_t e;
        kill = 1'b1;
        request(2'd0, 8'd3, 8'd4);
        void'(exp_q.pop_back());
        exp_q.push_back('{id: 2'd0, z: 16'd0, err: 1'b1});
        wait_rsp(200, n, starts);
        checks++;
        if (n != 4 * DW + 1) begin
            errors++;
            $display("FAIL timeout_latency: rsp_valid %0d cycles after ISSUE, required %0d", n, 4 * DW + 1);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_z, bus.rsp_err} !== {e.id, e.z, e.err}) begin
            errors++;
            $display("FAIL timeout_rsp: got id=%0d z=%0d err=%b, required id=%0d z=%0d err=%b",
                     bus.rsp_id, bus.rsp_z, bus.rsp_err, e.id, e.z, e.err);
        end
        kill = 1'b0;
        tick();
    endtask
`endif

    initial begin
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        kill = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < NR; i++) begin
            xs[i] = '0;
            ys[i] = '0;
        end
        test_reset();
        test_single();
        test_rotation();
        test_max();
        test_wrap();
        test_stall();
        test_stray_done();
        test_reset_mid();
`ifdef MUL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
